// File: rtl/xaui_link_sequencer.sv
// XAUI link bring-up and recovery sequencer: orders MGT TX/RX resets, waits for
// lock, sync and alignment, then supervises the link and retries with exponential backoff.
module xaui_link_sequencer #(
    parameter int TX_RST_CYCLES = 16,
    parameter int RX_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT  = 2**20,
    parameter int SYNC_TIMEOUT  = 2**16,
    parameter int ALIGN_TIMEOUT = 2**12,
    parameter int DEBOUNCE      = 4,
    parameter int BACKOFF_BASE  = 256,
    parameter int MAX_EXP       = 8,
    parameter int TIMER_BITS    = 24
) (
    input  logic        xaui_clk,
    input  logic        reset_n,
    input  logic [3:0]  mgt_rxlock,
    input  logic [3:0]  mgt_rxbufferr,
    input  logic [7:0]  xaui_status,
    input  logic        force_resync,
    output logic        mgt_tx_reset,
    output logic        mgt_rx_reset,
    output logic        cfg_reset_status,
    output logic        link_up,
    output logic [2:0]  seq_state,
    output logic [15:0] resync_count,
    output logic        lock_timeout
);

    localparam int EXP_BITS = (MAX_EXP < 1) ? 1 : $clog2(MAX_EXP + 1);
    localparam int DEB_BITS = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);

    localparam logic [TIMER_BITS-1:0] TX_LOAD    = TIMER_BITS'(TX_RST_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] RX_LOAD    = TIMER_BITS'(RX_RST_CYCLES - 1);
    localparam logic [TIMER_BITS-1:0] LOCK_LOAD  = TIMER_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_BITS-1:0] SYNC_LOAD  = TIMER_BITS'(SYNC_TIMEOUT - 1);
    localparam logic [TIMER_BITS-1:0] ALIGN_LOAD = TIMER_BITS'(ALIGN_TIMEOUT - 1);
    localparam logic [DEB_BITS-1:0]   DEB_LAST   = DEB_BITS'(DEBOUNCE - 1);
    localparam logic [EXP_BITS-1:0]   EXP_MAX    = EXP_BITS'(MAX_EXP);

    typedef enum logic [2:0] {
        TX_RST     = 3'd0,
        WAIT_LOCK  = 3'd1,
        RX_RST     = 3'd2,
        WAIT_SYNC  = 3'd3,
        WAIT_ALIGN = 3'd4,
        LINK_UP    = 3'd5,
        BACKOFF    = 3'd6,
        ILLEGAL    = 3'd7
    } state_t;

    state_t                state_q, state_d;
    logic [TIMER_BITS-1:0] timer_q, timer_d, backoff_load;
    logic [EXP_BITS-1:0]   fail_exp_q, fail_exp_d;
    logic [DEB_BITS-1:0]   debounce_q, debounce_d;
    logic                  all_lock, lanes_sync, aligned, fault, expired;
    logic                  lock_to_set, clear_exp, entering;
    logic                  unused_status;

    assign all_lock      = &mgt_rxlock;
    assign lanes_sync    = (xaui_status[5:2] == 4'hF);
    assign aligned       = (xaui_status[6:2] == 5'h1F);
    assign fault         = !aligned || (|mgt_rxbufferr);
    assign expired       = (timer_q == '0);
    assign entering      = (state_d != state_q);
    assign backoff_load  = (TIMER_BITS'(BACKOFF_BASE) << fail_exp_q) - TIMER_BITS'(1);
    assign seq_state     = state_q;
    assign unused_status = ^{xaui_status[7], xaui_status[1:0]};

    // Lock loss beats force_resync, which beats debounce and timeouts.
    always_comb begin
        state_d     = state_q;
        lock_to_set = 1'b0;
        clear_exp   = 1'b0;
        case (state_q)
            TX_RST: begin
                if (expired) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (all_lock) begin
                    state_d = RX_RST;
                end else if (expired) begin
                    state_d     = TX_RST;
                    lock_to_set = 1'b1;
                end
            end
            RX_RST: begin
                if (!all_lock)    state_d = TX_RST;
                else if (expired) state_d = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (!all_lock)       state_d = TX_RST;
                else if (lanes_sync) state_d = WAIT_ALIGN;
                else if (expired)    state_d = BACKOFF;
            end
            WAIT_ALIGN: begin
                if (!all_lock) begin
                    state_d = TX_RST;
                end else if (aligned) begin
                    state_d   = LINK_UP;
                    clear_exp = 1'b1;
                end else if (!lanes_sync || expired) begin
                    state_d = BACKOFF;
                end
            end
            LINK_UP: begin
                if (!all_lock)                          state_d = TX_RST;
                else if (force_resync)                  state_d = RX_RST;
                else if (fault && debounce_q == DEB_LAST) state_d = RX_RST;
            end
            BACKOFF: begin
                if (!all_lock)    state_d = TX_RST;
                else if (expired) state_d = RX_RST;
            end
            default: state_d = TX_RST;
        endcase
    end

    always_comb begin
        timer_d = timer_q;
        if (entering) begin
            case (state_d)
                TX_RST:     timer_d = TX_LOAD;
                WAIT_LOCK:  timer_d = LOCK_LOAD;
                RX_RST:     timer_d = RX_LOAD;
                WAIT_SYNC:  timer_d = SYNC_LOAD;
                WAIT_ALIGN: timer_d = ALIGN_LOAD;
                BACKOFF:    timer_d = backoff_load;
                default:    timer_d = '0;
            endcase
        end else if (!expired) begin
            timer_d = timer_q - TIMER_BITS'(1);
        end
    end

    always_comb begin
        fail_exp_d = fail_exp_q;
        if (clear_exp)
            fail_exp_d = '0;
        else if (entering && state_d == BACKOFF && fail_exp_q != EXP_MAX)
            fail_exp_d = fail_exp_q + EXP_BITS'(1);
        // Only consecutive faulty cycles spent inside LINK_UP count.
        debounce_d = '0;
        if (state_q == LINK_UP && state_d == LINK_UP && fault)
            debounce_d = debounce_q + DEB_BITS'(1);
    end

    always_ff @(posedge xaui_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= TX_RST;
            timer_q          <= TX_LOAD;
            fail_exp_q       <= '0;
            debounce_q       <= '0;
            resync_count     <= '0;
            lock_timeout     <= 1'b0;
            mgt_tx_reset     <= 1'b1;
            mgt_rx_reset     <= 1'b1;
            cfg_reset_status <= 1'b1;
            link_up          <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_exp_q <= fail_exp_d;
            debounce_q <= debounce_d;
            if (state_q == LINK_UP && state_d != LINK_UP && resync_count != 16'hFFFF)
                resync_count <= resync_count + 16'd1;
            if (lock_to_set)
                lock_timeout <= 1'b1;
            // Decoded from the next state so outputs move together with seq_state.
            mgt_tx_reset     <= (state_d == TX_RST);
            mgt_rx_reset     <= (state_d inside {TX_RST, WAIT_LOCK, RX_RST, BACKOFF});
            cfg_reset_status <= (state_d inside {TX_RST, RX_RST});
            link_up          <= (state_d == LINK_UP);
        end
    end

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// Bench for xaui_link_sequencer: segment tables of {inputs, state, duration}
// drive the link through bring-up, debounce, lock loss, timeouts and backoff.
module tb_xaui_link_sequencer;

    logic        xaui_clk;
    logic        reset_n;
    logic [3:0]  mgt_rxlock;
    logic [3:0]  mgt_rxbufferr;
    logic [7:0]  xaui_status;
    logic        force_resync;
    logic        mgt_tx_reset;
    logic        mgt_rx_reset;
    logic        cfg_reset_status;
    logic        link_up;
    logic [2:0]  seq_state;
    logic [15:0] resync_count;
    logic        lock_timeout;

    xaui_link_sequencer #(
        .TX_RST_CYCLES(4),
        .RX_RST_CYCLES(4),
        .LOCK_TIMEOUT (32),
        .SYNC_TIMEOUT (64),
        .ALIGN_TIMEOUT(16),
        .DEBOUNCE     (4),
        .BACKOFF_BASE (8),
        .MAX_EXP      (2),
        .TIMER_BITS   (24)
    ) dut (
        .xaui_clk        (xaui_clk),
        .reset_n         (reset_n),
        .mgt_rxlock      (mgt_rxlock),
        .mgt_rxbufferr   (mgt_rxbufferr),
        .xaui_status     (xaui_status),
        .force_resync    (force_resync),
        .mgt_tx_reset    (mgt_tx_reset),
        .mgt_rx_reset    (mgt_rx_reset),
        .cfg_reset_status(cfg_reset_status),
        .link_up         (link_up),
        .seq_state       (seq_state),
        .resync_count    (resync_count),
        .lock_timeout    (lock_timeout)
    );

    // clock / reset
    initial xaui_clk = 1'b0;
    always #5 xaui_clk = ~xaui_clk;

    typedef struct {
        logic [3:0]  lock;
        logic [7:0]  status;
        logic [3:0]  bufferr;
        logic        force_rs;
        int          cycles;
        logic [2:0]  st;
        logic        lt;
        logic [15:0] rc;
    } vec_t;

    vec_t        vecs[$];
    logic [23:0] exp_q[$];
    int          n_vec  = 0;
    int          n_miss = 0;

    // Expected output word {state, tx, rx, cfg, link_up, lock_timeout, resync_count}.
    function automatic logic [23:0] outs_for(input logic [2:0] st, input logic lt,
                                             input logic [15:0] rc);
        logic tx, rx, cfg, lu;
        tx  = (st == 3'd0);
        rx  = (st == 3'd0) || (st == 3'd1) || (st == 3'd2) || (st == 3'd6);
        cfg = (st == 3'd0) || (st == 3'd2);
        lu  = (st == 3'd5);
        return {st, tx, rx, cfg, lu, lt, rc};
    endfunction

    function automatic logic [23:0] dut_outs();
        return {seq_state, mgt_tx_reset, mgt_rx_reset, cfg_reset_status, link_up,
                lock_timeout, resync_count};
    endfunction

    // scoreboard
    task automatic compare_head(input string name);
        logic [23:0] e, g;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: scoreboard empty, got %h", name, dut_outs());
        end else begin
            e = exp_q.pop_front();
            g = dut_outs();
            if (g !== e) begin
                n_miss++;
                $display("FAIL %s: got st=%0d tx/rx/cfg/up=%b lt=%b rc=%0d, expected st=%0d tx/rx/cfg/up=%b lt=%b rc=%0d",
                         name, g[23:21], g[20:17], g[16], g[15:0],
                         e[23:21], e[20:17], e[16], e[15:0]);
            end
        end
    endtask

    // drivers
    task automatic add(input logic [3:0] lock, input logic [7:0] status,
                       input logic [3:0] bufferr, input logic frc, input int cycles,
                       input logic [2:0] st, input logic lt, input logic [15:0] rc);
        vec_t v;
        v.lock = lock; v.status = status; v.bufferr = bufferr; v.force_rs = frc;
        v.cycles = cycles; v.st = st; v.lt = lt; v.rc = rc;
        vecs.push_back(v);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            mgt_rxlock    = vecs[i].lock;
            xaui_status   = vecs[i].status;
            mgt_rxbufferr = vecs[i].bufferr;
            force_resync  = vecs[i].force_rs;
            for (int c = 0; c < vecs[i].cycles; c++) begin
                exp_q.push_back(outs_for(vecs[i].st, vecs[i].lt, vecs[i].rc));
                @(posedge xaui_clk);
                #1;
                compare_head($sformatf("%s.v%0d.c%0d", tag, i, c));
            end
        end
        vecs.delete();
    endtask

    initial begin
        reset_n       = 1'b0;
        mgt_rxlock    = 4'hF;
        mgt_rxbufferr = 4'h0;
        xaui_status   = 8'h00;
        force_resync  = 1'b0;
        repeat (2) @(posedge xaui_clk);
        #1;
        exp_q.push_back(outs_for(3'd0, 1'b0, 16'd0));
        compare_head("reset_values");
        @(negedge xaui_clk);
        reset_n = 1'b1;

        // Clean bring-up, debounce, ignored force, simultaneous events, no lock, sync never.
        add(4'hF, 8'h00, 4'h0, 1'b0,  3, 3'd0, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0,  1, 3'd1, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0,  4, 3'd2, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  1, 3'd3, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  1, 3'd4, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  3, 3'd5, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h4, 1'b0,  3, 3'd5, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  1, 3'd5, 1'b0, 16'd0);
        add(4'hF, 8'hBC, 4'h0, 1'b0,  3, 3'd5, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  1, 3'd5, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h4, 1'b0,  3, 3'd5, 1'b0, 16'd0);
        add(4'hF, 8'hFC, 4'h4, 1'b0,  1, 3'd2, 1'b0, 16'd1);
        add(4'hF, 8'hFC, 4'h0, 1'b1,  3, 3'd2, 1'b0, 16'd1);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  1, 3'd3, 1'b0, 16'd1);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  1, 3'd4, 1'b0, 16'd1);
        add(4'hF, 8'hFC, 4'h0, 1'b0,  2, 3'd5, 1'b0, 16'd1);
        add(4'h7, 8'hFC, 4'h0, 1'b1,  1, 3'd0, 1'b0, 16'd2);
        add(4'h7, 8'hFC, 4'h0, 1'b0,  3, 3'd0, 1'b0, 16'd2);
        add(4'h7, 8'hFC, 4'h0, 1'b0, 32, 3'd1, 1'b0, 16'd2);
        add(4'h7, 8'hFC, 4'h0, 1'b0,  4, 3'd0, 1'b1, 16'd2);
        add(4'h7, 8'hFC, 4'h0, 1'b0,  2, 3'd1, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0,  4, 3'd2, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 64, 3'd3, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0,  8, 3'd6, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0,  4, 3'd2, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 64, 3'd3, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 16, 3'd6, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0,  4, 3'd2, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 64, 3'd3, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 32, 3'd6, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0,  4, 3'd2, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 64, 3'd3, 1'b1, 16'd2);
        add(4'hF, 8'h00, 4'h0, 1'b0, 10, 3'd6, 1'b1, 16'd2);
        run_table("seq");

        // Reset mid-BACKOFF takes effect without a clock edge.
        #3;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(outs_for(3'd0, 1'b0, 16'd0));
        compare_head("async_reset");
        @(posedge xaui_clk);
        #1;
        exp_q.push_back(outs_for(3'd0, 1'b0, 16'd0));
        compare_head("reset_held");
        @(negedge xaui_clk);
        reset_n = 1'b1;

        // Backoff exponent restarts from zero after reset.
        add(4'hF, 8'h00, 4'h0, 1'b0,  3, 3'd0, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0,  1, 3'd1, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0,  4, 3'd2, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0, 64, 3'd3, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0,  8, 3'd6, 1'b0, 16'd0);
        add(4'hF, 8'h00, 4'h0, 1'b0,  1, 3'd2, 1'b0, 16'd0);
        run_table("post_reset");

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/xaui_link_sequencer.md
Name: xaui_link_sequencer

Overview:
Link bring-up and recovery controller for the 4-lane XAUI PHY on the ROACH2 base.
- Sequences the MGT TX and RX resets and waits for PLL lock, lane sync and alignment.
- Supervises the established link and re-runs RX reset with exponential backoff on faults.
- Its outputs drive the PHY's mgt_tx_reset, mgt_rx_reset and configuration-vector status-reset bits.
- It replaces the free-running retry timer inside the PHY.

Parameters:
TX_RST_CYCLES, 16, cycles TX reset is held
RX_RST_CYCLES, 16, cycles RX reset is held
LOCK_TIMEOUT, 2^20, cycles allowed for all four mgt_rxlock
SYNC_TIMEOUT, 2^16, cycles allowed for all lanes to sync
ALIGN_TIMEOUT, 2^12, cycles allowed for alignment after sync
DEBOUNCE, 4, consecutive fault cycles in LINK_UP before resync
BACKOFF_BASE, 256, base backoff cycles
MAX_EXP, 8, backoff exponent saturation
TIMER_BITS, 24, timer width; BACKOFF_BASE<<MAX_EXP and every timeout must be at most 2^TIMER_BITS-1

Ports:
xaui_clk  in  1  PHY user clock; the only clock
reset_n  in  1  asynchronous active-low reset
mgt_rxlock  in  4  per-lane PLL lock
mgt_rxbufferr  in  4  per-lane elastic buffer error
xaui_status  in  8  PHY status: [5:2] lane sync, [6] align, [7] rx link
force_resync  in  1  software single-cycle resync request
mgt_tx_reset  out  1  MGT TX reset
mgt_rx_reset  out  1  MGT/PHY RX reset
cfg_reset_status  out  1  drives configuration_vector bits [3:2]
link_up  out  1  link established
seq_state  out  3  current state encoding
resync_count  out  16  saturating count of LINK_UP exits
lock_timeout  out  1  sticky: a lock timeout has occurred

Behaviour:
- States and encodings: TX_RST=0, WAIT_LOCK=1, RX_RST=2, WAIT_SYNC=3, WAIT_ALIGN=4, LINK_UP=5, BACKOFF=6. Code 7 is illegal and recovers to TX_RST.
- Reset (async assert, sync release): state TX_RST, timer=TX_RST_CYCLES-1, mgt_tx_reset=1, mgt_rx_reset=1, cfg_reset_status=1, link_up=0, resync_count=0, lock_timeout=0, fail_exp=0, debounce=0.
- All outputs are registered and decoded from next-state, so they change in the same cycle seq_state changes.
- Timer: a single TIMER_BITS down-counter. On every state entry it is loaded with N-1 for the state's duration N. Timer==0 marks expiry.
- TX_RST: tx=1, rx=1. On expiry go to WAIT_LOCK.
- WAIT_LOCK: tx=0, rx=1.
  - If &mgt_rxlock, go to RX_RST.
  - Otherwise on expiry set lock_timeout and go to TX_RST.
- RX_RST: rx=1, cfg_reset_status=1. On expiry go to WAIT_SYNC.
- WAIT_SYNC: rx=0. If xaui_status[5:2]==4'hF go to WAIT_ALIGN, else on expiry go to BACKOFF.
- WAIT_ALIGN:
  - If status[6:2]==5'h1F go to LINK_UP; fail_exp is cleared.
  - A drop of any sync bit, or expiry, goes to BACKOFF.
- LINK_UP: link_up=1.
  - Fault is defined as (status[6:2]!=5'h1F) | (|mgt_rxbufferr).
  - The debounce counter increments on fault and clears on any clean cycle. At DEBOUNCE consecutive fault cycles go to RX_RST.
  - force_resync goes to RX_RST on the next edge.
  - Each LINK_UP exit increments resync_count, saturating at 16'hFFFF.
- BACKOFF: rx=1.
  - On entry the timer is loaded with (BACKOFF_BASE<<fail_exp)-1, and fail_exp increments, saturating at MAX_EXP.
  - On expiry go to RX_RST.
- Priority in all states after WAIT_LOCK: loss of any mgt_rxlock goes to TX_RST. This overrides force_resync, which overrides debounce and timeout.
- force_resync outside LINK_UP is ignored.
- cfg_reset_status is 0 in every state except TX_RST and RX_RST.
- Reset asserted mid-sequence returns to the reset values immediately. lock_timeout clears only on reset_n.

Test Plan:
Use overrides TX_RST_CYCLES=4, RX_RST_CYCLES=4, LOCK_TIMEOUT=32, SYNC_TIMEOUT=64, ALIGN_TIMEOUT=16, DEBOUNCE=4, BACKOFF_BASE=8, MAX_EXP=2.
- Clean bring-up: rxlock=F from reset, status[6:2]=1F from the first WAIT_SYNC cycle -> mgt_tx_reset falls 4 cycles after reset release; mgt_rx_reset held for 4 RX_RST cycles; link_up=1 two cycles later; resync_count=0.
- No lock: rxlock=7 held -> after 32 WAIT_LOCK cycles lock_timeout=1 and seq_state=0; loops with tx=1 for 4 cycles.
- Sync never: status=0 -> WAIT_SYNC 64 cycles, then BACKOFF lengths of 8, 16, 32, 32 on successive failures; mgt_rx_reset=1 throughout each backoff.
- Fault debounce in LINK_UP: rxbufferr[2] pulses for 3 cycles -> stays in LINK_UP. Held for 4 cycles -> RX_RST, resync_count=1, link_up=0 in the same cycle.
- Simultaneous events in LINK_UP: force_resync and rxlock drop in the same cycle -> TX_RST, not RX_RST; resync_count increments by 1.
- Mid-sequence reset: reset_n low during BACKOFF -> all outputs at reset values immediately (asynchronously); fail_exp cleared, so the first later backoff is 8 cycles.
